serial_sub: RTL and testbench
=============================

# serial_sub

Parametrised multi-cycle subtractor computing `diff = a - b - bin` over `WIDTH` bits, `DIGIT` bits per clock, LSB digit first. It extends the single-bit half-subtractor to full-width operands with borrow-in, borrow-out, signed overflow and a start/ready/valid handshake. It sits in the arithmetic datapath wherever a subtract is needed and single-cycle ripple timing or area is unacceptable.

## Interface
- `WIDTH`, default 8: operand width; must be a multiple of `DIGIT`.
- `DIGIT`, default 1: bits processed per cycle; `STEPS = WIDTH/DIGIT`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted when `ready=1`.
- `a`  in  WIDTH  minuend; sampled only on the accepting edge.
- `b`  in  WIDTH  subtrahend; sampled only on the accepting edge.
- `bin`  in  1  borrow-in; sampled only on the accepting edge.
- `ready`  out  1  high in IDLE and DONE.
- `valid`  out  1  one-cycle pulse; result available.
- `diff`  out  WIDTH  difference, modulo 2^WIDTH.
- `bout`  out  1  unsigned borrow-out (1 when `a < b + bin`).
- `ovf`  out  1  signed two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `ready=1`. `start=1` -> latch `a`, `b`, `bin` into operand and borrow registers, clear step counter, go to RUN.
- RUN: `ready=0`. Each cycle, the digit at index `count` (bits `count*DIGIT +: DIGIT`) is subtracted with the running borrow, written into the same slice of `diff`, and the borrow register is updated. `count` increments. On `count == STEPS-1`, go to DONE.
- `start` during RUN is ignored; operands latched at acceptance are not disturbed.
- DONE: `valid=1`, `ready=1`. `start=1` -> accept new operands and go to RUN (back-to-back), else go to IDLE.
- `bout` is the borrow out of bit `WIDTH-1`.
- `ovf` is the borrow into bit `WIDTH-1` XOR the borrow out of bit `WIDTH-1`.
- `diff`, `bout` and `ovf` hold their values from DONE until the next accepted `start`. Once a new request is accepted, `diff` slices update progressively and are not valid until `valid`.
- All subtraction is unsigned modulo arithmetic. Signed interpretation affects only `ovf`.

## Timing
- Reset (synchronous, priority over everything): state=IDLE, `ready=1`, `valid=0`, `diff=0`, `bout=0`, `ovf=0`, counter=0.
- `rst` asserted mid-RUN: the operation is abandoned at the next edge, with no `valid` pulse.
- If `start` is sampled at edge 0, digit steps occur at edges 1..STEPS, and `valid` is high from edge STEPS to STEPS+1.
- Latency is STEPS+1 cycles from start to valid. With back-to-back `start` in DONE, throughput is one result per STEPS+1 cycles.
- `valid` is never high for more than one consecutive cycle.
- `WIDTH % DIGIT != 0` is an elaboration error (`$error` in the generate).

## Structure
- Package `sub_pkg`: state enum (IDLE/RUN/DONE), `steps(WIDTH,DIGIT)` function, counter width `$clog2(STEPS)` (minimum 1).
- Sub-module `sub_digit`: combinational `DIGIT`-bit ripple of full-subtractor cells.
  - Inputs: `x`, `y`, `bi`.
  - Outputs: `d`, `bo`, and `bmsb` (the borrow into the cell's top bit, used for `ovf`).
- A single `sub_digit` instance is reused every step. The FSM, counter, operand registers and result register live in `serial_sub`.

## Test plan
- Reset, then idle: `rst` 2 cycles -> `ready=1`, `valid=0`, `diff=0`, `bout=0`, `ovf=0`. With `start=0` and no `rst`, `valid` stays 0 for 20 cycles.
- WIDTH=8, DIGIT=1: `a=8'h05`, `b=8'h03`, `bin=0` -> after 9 cycles, `valid` pulses once with `diff=8'h02`, `bout=0`, `ovf=0`. Then `a=8'h03`, `b=8'h05` -> `diff=8'hFE`, `bout=1`, `ovf=0`.
- Signed overflow, WIDTH=8, DIGIT=4: `a=8'h80`, `b=8'h01`, `bin=0` -> `diff=8'h7F`, `bout=0`, `ovf=1`, with `valid` 3 cycles after start. Then `a=8'h00`, `b=8'h00`, `bin=1` -> `diff=8'hFF`, `bout=1`, `ovf=0`.
- Operand change and spurious `start` during RUN: drive `a`, `b` to different values and pulse `start` mid-RUN -> result matches the originally latched operands, and the mid-RUN `start` is not accepted.
- Back-to-back: assert `start` in the DONE cycle with new operands -> the next `valid` arrives exactly STEPS+1 cycles after the first.
- Reset mid-RUN: assert `rst` at step 3 -> no `valid`, outputs return to reset values. Compare against a reference model over 1000 random `a`/`b`/`bin` for DIGIT=1, 2, 8.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Number of digit steps needed to cover the full operand width.
  function automatic int unsigned steps(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // Step counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// Combinational DIGIT-bit ripple of full-subtractor cells.
module sub_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo,
  output logic             bmsb
);

  logic w_c;

  // Ripple the borrow from bit 0 upwards; bmsb captures the borrow into the top bit.
  always_comb begin
    w_c  = bi;
    d    = '0;
    bmsb = 1'b0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) begin
        bmsb = w_c;
      end
      d[i] = x[i] ^ y[i] ^ w_c;
      w_c  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_c);
    end
    bo = w_c;
  end

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock, LSB digit first.
module serial_sub
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned STEPS = steps(WIDTH, DIGIT);
  localparam int unsigned CW    = cnt_width(STEPS);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_sub: WIDTH must be a multiple of DIGIT");
  end

  state_t           r_state;
  state_t           w_next;
  logic             w_ready;
  logic             w_valid;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic [DIGIT-1:0] w_x;
  logic [DIGIT-1:0] w_y;
  logic [DIGIT-1:0] w_d;
  logic             w_bo;
  logic             w_bmsb;

  assign w_accept = start && w_ready;
  assign w_last   = (r_count == CW'(STEPS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (start) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        w_ready = 1'b1;
        w_valid = 1'b1;
        w_next  = start ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Select the operand digits addressed by the step counter.
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      if (r_count == CW'(i)) begin
        w_x = r_a[i*DIGIT +: DIGIT];
        w_y = r_b[i*DIGIT +: DIGIT];
      end
    end
  end

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x    (w_x),
    .y    (w_y),
    .bi   (r_borrow),
    .d    (w_d),
    .bo   (w_bo),
    .bmsb (w_bmsb)
  );

  // Operand capture on acceptance, then one digit step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_count  <= '0;
    end else if (r_state == RUN) begin
      r_borrow <= w_bo;
      r_count  <= r_count + CW'(1);
      for (int unsigned i = 0; i < STEPS; i++) begin
        if (r_count == CW'(i)) begin
          r_diff[i*DIGIT +: DIGIT] <= w_d;
        end
      end
      if (w_last) begin
        r_bout <= w_bo;
        r_ovf  <= w_bmsb ^ w_bo;
      end
    end
  end

  assign ready = w_ready;
  assign valid = w_valid;
  assign diff  = r_diff;
  assign bout  = r_bout;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench: four serial_sub instances (DIGIT = 1, 2, 4, 8; WIDTH = 8).
module tb_serial_sub;

  typedef struct {
    int         k;
    logic [7:0] d;
    logic       bo;
    logic       ov;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic [3:0] ready;
  logic [3:0] valid;
  logic [3:0] bout;
  logic [3:0] ovf;
  logic [7:0] diff [4];

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   nvalid = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s[dut%0d] got=%0h expected=%0h at cycle %0d", name, k, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed readings.
  function automatic exp_t model(input int k, input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    exp_t e;
    int   u;
    int   s;
    u     = int'(ta) - int'(tb) - int'(tbin);
    s     = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
    e.k   = k;
    e.d   = u[7:0];
    e.bo  = (u < 0);
    e.ov  = (s > 127) || (s < -128);
    e.due = cyc + 1 + (8 >> k);
    return e;
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_dut
    serial_sub #(.WIDTH(8), .DIGIT(1 << k)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start[k]),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .ready (ready[k]),
      .valid (valid[k]),
      .diff  (diff[k]),
      .bout  (bout[k]),
      .ovf   (ovf[k])
    );

    logic r_prev = 1'b0;

    // Monitor: pop this instance's oldest expectation on every valid.
    always @(negedge clk) begin
      int   idx;
      exp_t e;
      if (rst) begin
        r_prev = 1'b0;
      end else begin
        if (valid[k]) begin
          nvalid++;
          cmp("valid_single_cycle", k, 32'(r_prev), 32'd0);
          idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].k == k) idx = i;
          end
          checks++;
          if (idx < 0) begin
            fails++;
            $display("FAIL unexpected_valid[dut%0d] got=valid expected=none at cycle %0d", k, cyc);
          end else begin
            e = sb[idx];
            sb.delete(idx);
            cmp("diff", k, 32'(diff[k]), 32'(e.d));
            cmp("bout", k, 32'(bout[k]), 32'(e.bo));
            cmp("ovf", k, 32'(ovf[k]), 32'(e.ov));
            cmp("valid_cycle", k, 32'(cyc), 32'(e.due));
          end
        end
        r_prev = valid[k];
      end
    end
  end

  task automatic fire(input logic [3:0] m, input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    a     = ta;
    b     = tb;
    bin   = tbin;
    start = m;
    @(posedge clk); #1;
    start = '0;
  endtask

  task automatic issue_model(input logic [3:0] m, input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    for (int k = 0; k < 4; k++) begin
      if (m[k]) sb.push_back(model(k, ta, tb, tbin));
    end
    fire(m, ta, tb, tbin);
  endtask

  task automatic issue_const(input int k, input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                             input logic [7:0] ed, input logic eb, input logic eo);
    exp_t e;
    e.k   = k;
    e.d   = ed;
    e.bo  = eb;
    e.ov  = eo;
    e.due = cyc + 1 + (8 >> k);
    sb.push_back(e);
    fire(4'(1 << k), ta, tb, tbin);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ready != 4'hF || sb.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      fails++;
      $display("FAIL idle_timeout got=%0d pending expected=0 at cycle %0d", sb.size(), cyc);
      sb.delete();
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset();
    for (int k = 0; k < 4; k++) begin
      cmp("rst_ready", k, 32'(ready[k]), 32'd1);
      cmp("rst_valid", k, 32'(valid[k]), 32'd0);
      cmp("rst_diff", k, 32'(diff[k]), 32'd0);
      cmp("rst_bout", k, 32'(bout[k]), 32'd0);
      cmp("rst_ovf", k, 32'(ovf[k]), 32'd0);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout expected=finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nv0;
    int n;
    rst   = 1'b1;
    start = '0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();

    nv0 = nvalid;
    repeat (20) begin
      @(posedge clk); #1;
    end
    cmp("idle_no_valid", 0, 32'(nvalid), 32'(nv0));

    // Directed cases on DIGIT=1 and DIGIT=4.
    issue_const(0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    wait_idle();
    issue_const(0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    wait_idle();
    issue_const(2, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    wait_idle();
    issue_const(2, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_idle();

    // Operands change and start pulses mid-RUN; latched values must win.
    issue_const(0, 8'h3C, 8'h5A, 1'b1, 8'hE1, 1'b1, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    fire(4'b0001, 8'hFF, 8'h00, 1'b0);
    a = 8'h11;
    b = 8'h77;
    wait_idle();

    // Back-to-back on DIGIT=2: second request accepted in the DONE cycle.
    issue_model(4'b0010, 8'($urandom), 8'($urandom), 1'($urandom));
    n = 0;
    while (!ready[1] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    issue_model(4'b0010, 8'($urandom), 8'($urandom), 1'($urandom));
    wait_idle();

    // Reset during step 3 on DIGIT=1 and DIGIT=2: abandoned, no valid.
    issue_model(4'b0011, 8'hA5, 8'h3C, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset();
    nv0 = nvalid;
    repeat (12) begin
      @(posedge clk); #1;
    end
    cmp("post_rst_no_valid", 0, 32'(nvalid), 32'(nv0));

    // Random operands on all widths, inputs scrambled while running.
    for (int it = 0; it < 1000; it++) begin
      issue_model(4'hF, 8'($urandom), 8'($urandom), 1'($urandom));
      n = 0;
      while ((ready != 4'hF || sb.size() != 0) && n < 50) begin
        a   = 8'($urandom);
        b   = 8'($urandom);
        bin = 1'($urandom);
        @(posedge clk); #1;
        n++;
      end
      if (n >= 50) begin
        checks++;
        fails++;
        $display("FAIL random_timeout got=%0d pending expected=0 at iteration %0d", sb.size(), it);
        sb.delete();
      end
    end
    wait_idle();

    cmp("scoreboard_empty", 0, 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
